mem_req_ctrl: RTL and testbench
===============================

Name: mem_req_ctrl

Overview:
- Initiator-side controller that drives one port of the team's synchronous dual-port block RAM.
- RAM port contract: address/data/write-enable sampled on the clock edge. Read data is registered with 1-cycle latency. A write returns its write data on dout the following cycle (write-first).
- Converts a valid/ready request stream into RAM port cycles.
- Captures read data into a response FIFO with valid/ready backpressure. Uses credit-based issue so no read data is ever lost.

Parameters:
- ADDR_W, 10, RAM address width (1024 words).
- DATA_W, 16, data word width.
- RSP_DEPTH, 4, response FIFO depth and maximum outstanding reads (power of 2, ≥2).

Ports:
- i_clk  in  1  single clock, shared with the RAM port it drives.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted when valid&ready ("fire").
- i_req_we  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_W  request address.
- i_req_wdata  in  DATA_W  write data (ignored for reads).
- o_rsp_valid  out  1  response data available.
- i_rsp_ready  in  1  consumer takes response when valid&ready.
- o_rsp_data  out  DATA_W  response data (FIFO head).
- o_mem_addr  out  ADDR_W  to RAM address.
- o_mem_din  out  DATA_W  to RAM write data.
- o_mem_wen  out  1  to RAM write enable.
- i_mem_dout  in  DATA_W  from RAM registered read data.

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: o_req_ready=0 while i_rst is high, o_rsp_valid=0, FIFO empty, rd_pend=0, occupancy=0. o_mem_wen=0 whenever no write fires.
- RAM drive is combinational from the request:
  - o_mem_addr=i_req_addr
  - o_mem_din=i_req_wdata
  - o_mem_wen=fire & i_req_we
- Credits: occupancy = FIFO count + rd_pend, both registered.
  - o_req_ready = !i_rst_state & (occupancy < RSP_DEPTH).
  - o_req_ready is a function of registers only. There is no combinational path from i_req_valid, i_req_we or i_rsp_ready.
- Read fired in cycle N:
  - rd_pend=1 during N+1.
  - i_mem_dout is pushed into the FIFO at the end of N+1.
  - o_rsp_valid=1 from N+2.
  - Minimum latency from fire to response is 2 cycles, fixed. There is no bypass.
- Write fired, feature disabled: RAM written at the edge ending cycle N. No response, no credit consumed beyond that cycle.
- Throughput: 1 request per cycle sustained while i_rsp_ready=1. Responses are strictly in request order.
- FIFO push and pop in the same cycle:
  - count unchanged.
  - The freed credit appears in o_req_ready the next cycle.
- FIFO full plus rd_pend is impossible by construction (credit check). Verification asserts this never occurs.
- Address wrap: ADDR_W-bit address, no range check. Address 2^ADDR_W-1 is legal.
- Reset mid-operation: the pending read is discarded and the FIFO is flushed. No stale response appears after deassertion. RAM contents are untouched; a write fired in the reset cycle is not guaranteed.
- o_rsp_data is undefined when o_rsp_valid=0. The bench must not check it.

Optional Feature:
- Macro: MEM_REQ_CTRL_WRITE_ACK_EN.
- Defined:
  - A write also consumes a credit and sets rd_pend.
  - The write-first RAM dout (equal to i_req_wdata) is pushed as a write-acknowledge response, with the same 2-cycle latency and ordering as reads.
- Undefined: writes produce no response and need no credit. o_req_ready is still registered-only and identical for reads and writes.

Decomposition:
- Shared package/header mem_pkg:
  - default ADDR_W and DATA_W constants.
  - RAM read latency constant MEM_RD_LAT=1, which sizes rd_pend.
- One sub-module: mem_rsp_fifo, a synchronous FIFO.
  - Parameters DATA_W and RSP_DEPTH.
  - Outputs a count; push/pop ports.
  - Registered-free head output (o_rsp_data = storage[rd_ptr]).
- Top level: credit/rd_pend logic plus RAM signal drive. Target size is about 200 lines total.

Test Plan:
- Write 0x1234 to addr 5, then read addr 5 with i_rsp_ready=1 → o_mem_wen pulses once. o_rsp_valid rises exactly 2 cycles after the read fires, with data 0x1234. No response for the write (feature off).
- Hold i_rsp_ready=0 and offer 6 reads → exactly 4 accepted and o_req_ready=0 after the 4th. Pop one → o_req_ready=1 the following cycle and the 5th read is accepted.
- Preload addr 0..7 with 0x100+addr, then issue 8 back-to-back reads with i_rsp_ready=1 → 8 responses 0x100..0x107 in order on consecutive cycles. o_req_ready stays 1 throughout.
- Write 0xFFFF to addr 1023, read 1023 → response 0xFFFF. No aliasing with addr 0, which reads its preloaded value.
- With 2 entries in the FIFO and a read pending, assert i_rst for 1 cycle → o_rsp_valid=0 immediately. After release, o_req_ready=1 and no response appears for 5 idle cycles.
- With MEM_REQ_CTRL_WRITE_ACK_EN: write 0xBEEF to addr 3 → response 0xBEEF 2 cycles later. Interleaved write/read/write → 3 responses in order.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the block-RAM request controller and its response FIFO.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_pkg;

    localparam int ADDR_W_DEF    = 10;  // 1024-word RAM
    localparam int DATA_W_DEF    = 16;
    localparam int RSP_DEPTH_DEF = 4;

    // Registered read data of the dual-port RAM: one cycle from address to dout.
    // Sizes the in-flight read shift register in the controller.
    localparam int MEM_RD_LAT    = 1;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Response FIFO: synchronous, power-of-2 depth, head word visible combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller's credit scheme guarantees no overflow.
//
// Ports:
//   i_clk, i_rst        clock, async active-high reset (pointers/count only)
//   i_push, i_push_data write one word
//   i_pop               discard the head word
//   o_data              head word (storage[rd_ptr]), meaningless when o_count==0
//   o_count             number of stored words, 0..RSP_DEPTH
module mem_rsp_fifo #(
    parameter int  DATA_W    = 16,
    parameter int  RSP_DEPTH = 4,
    localparam int PTR_W     = $clog2(RSP_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] storage [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Guards keep the pointers sane even if a caller misbehaves.
    assign do_pop  = i_pop & (o_count != '0);
    assign do_push = i_push & ((o_count != CNT_W'(RSP_DEPTH)) | do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   o_count <= o_count + CNT_W'(1);
                2'b01:   o_count <= o_count - CNT_W'(1);
                default: o_count <= o_count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read until the count says it is valid.
    always_ff @(posedge i_clk) begin
        if (do_push) storage[wr_ptr] <= i_push_data;
    end

    assign o_data = storage[rd_ptr];

endmodule

// File: rtl/mem_req_ctrl.sv
// Initiator-side controller for one port of the synchronous (write-first) block RAM.
// Latency: fire-to-response fixed at 2 cycles (RAM read stage + FIFO push), no bypass.
// Backpressure: credit-based; o_req_ready drops when FIFO count + reads in flight reach RSP_DEPTH.
//
// Optional feature macro: MEM_REQ_CTRL_WRITE_ACK_EN -- writes consume a credit and
// return their write-first dout as an acknowledge response, ordered with reads.
//
// Ports:
//   i_clk, i_rst                          clock, async active-high reset
//   i_req_valid/o_req_ready               request handshake
//   i_req_we, i_req_addr, i_req_wdata     request payload
//   o_rsp_valid/i_rsp_ready, o_rsp_data   response handshake and FIFO head data
//   o_mem_addr, o_mem_din, o_mem_wen      RAM port drive (combinational from request)
//   i_mem_dout                            RAM registered read data
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_din,
    output logic              o_mem_wen,
    input  logic [DATA_W-1:0] i_mem_dout
);

    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic                  rst_q;     // high from reset until the first clock after release
    logic [MEM_RD_LAT-1:0] rd_pend;   // one bit per RAM pipeline stage carrying a response
    logic [CNT_W-1:0]      fifo_count;
    logic [OCC_W-1:0]      occupancy;
    logic                  fire;
    logic                  rsp_fire;  // this request will produce a response
    logic                  push;
    logic                  pop;

    assign fire = i_req_valid & o_req_ready;

`ifdef MEM_REQ_CTRL_WRITE_ACK_EN
    assign rsp_fire = fire;
`else
    assign rsp_fire = fire & ~i_req_we;
`endif

    // RAM port follows the request directly; the write only happens on a fire.
    assign o_mem_addr = i_req_addr;
    assign o_mem_din  = i_req_wdata;
    assign o_mem_wen  = fire & i_req_we;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rst_q   <= 1'b1;
            rd_pend <= '0;
        end else begin
            rst_q   <= 1'b0;
            rd_pend <= (rd_pend << 1) | MEM_RD_LAT'(rsp_fire);
        end
    end

    // Credits in use: words already stored plus words still inside the RAM pipeline.
    always_comb begin
        occupancy = {1'b0, fifo_count};
        for (int k = 0; k < MEM_RD_LAT; k++) begin
            occupancy = occupancy + OCC_W'(rd_pend[k]);
        end
    end

    // Registers only: no path from valid/we/rsp_ready, so a same-cycle pop frees
    // its credit one cycle later.
    assign o_req_ready = ~rst_q & (occupancy < OCC_W'(RSP_DEPTH));

    assign push        = rd_pend[MEM_RD_LAT-1];
    assign o_rsp_valid = (fifo_count != '0);
    assign pop         = o_rsp_valid & i_rsp_ready;

    mem_rsp_fifo #(
        .DATA_W    (DATA_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_data (i_mem_dout),
        .i_pop       (pop),
        .o_data      (o_rsp_data),
        .o_count     (fifo_count)
    );

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: RAM model, queue-based reference model, directed plus random stimulus.
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [9:0]  mem_addr;
    logic [15:0] mem_din;
    logic        mem_wen;
    logic [15:0] mem_dout;

    always #5 clk = ~clk;

    mem_req_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_mem_addr  (mem_addr),
        .o_mem_din   (mem_din),
        .o_mem_wen   (mem_wen),
        .i_mem_dout  (mem_dout)
    );

    // Write-first synchronous RAM with registered dout.
    logic [15:0] ram [1024];
    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_din;
        mem_dout <= mem_wen ? mem_din : ram[mem_addr];
    end

    // Reference model: every accepted response-producing request becomes a queue
    // entry, available 2 cycles after its fire; the queue length is the credit use.
    typedef struct {
        logic [15:0] data;
        bit          known;
        int          avail;
    } exp_t;
    typedef struct {
        logic [15:0] data;
        int          cyc;
    } obs_t;

    exp_t        q[$];
    obs_t        log_q[$];
    logic [15:0] mmem [1024];
    bit          mknown [1024];
    bit          m_rst = 1'b1;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          wen_cnt = 0;
    bit          last_fire;
    bit          last_ready;
    int          last_fire_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        bit   er, ev, fire, pop;
        exp_t e;
        @(negedge clk);
        if (rst) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            q.delete();
            m_rst     = 1'b1;
            last_fire = 1'b0;
            last_ready = req_ready;
        end else begin
            er = !m_rst && (q.size() < 4);
            ev = (q.size() > 0) && (q[0].avail <= cyc);
            chk("req_ready", req_ready, er);
            chk("rsp_valid", rsp_valid, ev);
            if (ev && q[0].known) chk("rsp_data", rsp_data, q[0].data);
            fire = req_valid && er;
            chk("mem_wen", mem_wen, fire && req_we);
            chk("mem_addr", mem_addr, req_addr);
            chk("mem_din", mem_din, req_wdata);
            chk("full_with_pend", (dut.u_fifo.o_count == 4) && (dut.rd_pend != 0), 0);
            pop = ev && rsp_ready;
            if (rsp_valid && rsp_ready) log_q.push_back('{data: rsp_data, cyc: cyc});
            if (mem_wen) wen_cnt++;
            if (pop) e = q.pop_front();
            if (fire) begin
                if (req_we) begin
                    mmem[req_addr]   = req_wdata;
                    mknown[req_addr] = 1'b1;
`ifdef MEM_REQ_CTRL_WRITE_ACK_EN
                    q.push_back('{data: req_wdata, known: 1'b1, avail: cyc + 2});
`endif
                end else begin
                    q.push_back('{data: mmem[req_addr], known: mknown[req_addr], avail: cyc + 2});
                end
            end
            last_fire     = fire;
            last_fire_cyc = cyc;
            last_ready    = req_ready;
            m_rst         = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_req(input bit we, input logic [9:0] a, input logic [15:0] d, output int fc);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        fc        = -1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (last_fire) begin
                fc = last_fire_cyc;
                break;
            end
        end
        chk("req_accept_timeout", last_fire, 1);
        req_valid = 1'b0;
    endtask

    int fc, fc0, n_acc, n_low;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        rst = 1'b0;
        idle(2);
        chk("ready_after_reset", req_ready, 1);

        // Write then read-back of the same word.
        rsp_ready = 1'b1;
        log_q.delete();
        wen_cnt = 0;
        do_req(1'b1, 10'd5, 16'h1234, fc);
        do_req(1'b0, 10'd5, 16'h0000, fc);
        idle(4);
        chk("t1_wen_pulses", wen_cnt, 1);
`ifdef MEM_REQ_CTRL_WRITE_ACK_EN
        chk("t1_rsp_count", log_q.size(), 2);
`else
        chk("t1_rsp_count", log_q.size(), 1);
`endif
        if (log_q.size() > 0) begin
            chk("t1_rsp_data", log_q[log_q.size()-1].data, 16'h1234);
            chk("t1_rsp_latency", log_q[log_q.size()-1].cyc, fc + 2);
        end

        // Credit exhaustion with a stalled consumer.
        rsp_ready = 1'b0;
        log_q.delete();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd5;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (last_fire) n_acc++;
        end
        chk("t2_accepted", n_acc, 4);
        chk("t2_ready_low", last_ready, 0);
        req_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0; req_valid = 1'b1;
        tick();
        chk("t2_ready_after_pop", last_ready, 1);
        chk("t2_fifth_fire", last_fire, 1);
        rsp_ready = 1'b1;
        idle(8);
        chk("t2_rsp_count", log_q.size(), 5);

        // Preload then 8 back-to-back reads.
        for (int i = 0; i < 8; i++) do_req(1'b1, 10'(i), 16'h100 + 16'(i), fc);
        idle(4);
        log_q.delete();
        n_acc = 0; n_low = 0; fc0 = -1;
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_addr = 10'(i);
            tick();
            if (last_fire) n_acc++;
            if (!last_ready) n_low++;
            if (i == 0) fc0 = last_fire_cyc;
        end
        idle(4);
        chk("t3_accepted", n_acc, 8);
        chk("t3_ready_low_cycles", n_low, 0);
        chk("t3_rsp_count", log_q.size(), 8);
        if (log_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t3_rsp_data", log_q[i].data, 16'h100 + 16'(i));
                chk("t3_rsp_cycle", log_q[i].cyc, fc0 + 2 + i);
            end
        end

        // Top address, no aliasing onto address 0.
        do_req(1'b1, 10'd1023, 16'hFFFF, fc);
        idle(3);
        log_q.delete();
        do_req(1'b0, 10'd1023, 16'h0, fc);
        do_req(1'b0, 10'd0, 16'h0, fc);
        idle(4);
        chk("t4_rsp_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t4_top_addr", log_q[0].data, 16'hFFFF);
            chk("t4_addr0", log_q[1].data, 16'h0100);
        end

        // Reset with two stored responses and one read in flight.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0;
        n_acc = 0;
        for (int i = 1; i <= 3; i++) begin
            req_addr = 10'(i);
            tick();
            if (last_fire) n_acc++;
        end
        chk("t5_accepted", n_acc, 3);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_rsp_valid_in_reset", rsp_valid, 0);
        tick();
        rst = 1'b0;
        log_q.delete();
        rsp_ready = 1'b1;
        idle(6);
        chk("t5_ready_after_release", last_ready, 1);
        chk("t5_no_stale_rsp", log_q.size(), 0);

`ifdef MEM_REQ_CTRL_WRITE_ACK_EN
        log_q.delete();
        do_req(1'b1, 10'd3, 16'hBEEF, fc);
        idle(4);
        chk("t6_ack_count", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("t6_ack_data", log_q[0].data, 16'hBEEF);
            chk("t6_ack_latency", log_q[0].cyc, fc + 2);
        end
        log_q.delete();
        req_valid = 1'b1;
        req_we = 1'b1; req_addr = 10'd7; req_wdata = 16'hAAAA; tick();
        req_we = 1'b0; req_addr = 10'd3;                       tick();
        req_we = 1'b1; req_addr = 10'd8; req_wdata = 16'h5555; tick();
        idle(5);
        chk("t6_mix_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t6_mix_0", log_q[0].data, 16'hAAAA);
            chk("t6_mix_1", log_q[1].data, 16'hBEEF);
            chk("t6_mix_2", log_q[2].data, 16'h5555);
        end
`endif

        // Random traffic, including occasional mid-stream resets.
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom % 4) != 0;
            req_we    = $urandom % 2;
            case ($urandom % 4)
                0:       req_addr = 10'd1023;
                1:       req_addr = 10'd1022;
                default: req_addr = 10'($urandom % 16);
            endcase
            req_wdata = 16'($urandom);
            rsp_ready = ($urandom % 3) != 0;
            rst       = ($urandom % 200) == 0;
            tick();
        end
        rst = 1'b0;
        rsp_ready = 1'b1;
        idle(8);
        chk("final_drained", rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
